// File: rtl/rob_pkg.sv
// rob_pkg: reorder buffer sizing and instruction kind encodings shared by the ROB files
package rob_pkg;
    localparam int ROB_WIDTH = 3;
    localparam int ROB_SIZE = 1 << ROB_WIDTH;
    typedef enum logic [1:0] {
        KIND_REG = 2'd0,
        KIND_BR  = 2'd1,
        KIND_ST  = 2'd2
    } kind_t;
endpackage

// File: rtl/rob_query.sv
// rob_query: combinational operand lookup into the ROB with ALU/LSB broadcast bypass
module rob_query
    import rob_pkg::*;
(
    input  logic [ROB_WIDTH-1:0]       id,
    input  logic [ROB_SIZE-1:0]        ready_vec,
    input  logic [ROB_SIZE-1:0][31:0]  value_vec,
    input  logic                       alu_ready,
    input  logic [ROB_WIDTH-1:0]       alu_rob_id,
    input  logic [31:0]                alu_value,
    input  logic                       lsb_ready,
    input  logic [ROB_WIDTH-1:0]       lsb_rob_id,
    input  logic [31:0]                lsb_value,
    output logic                       ready,
    output logic [31:0]                value
);
    logic alu_hit, lsb_hit;

    always_comb begin
        alu_hit = alu_ready && alu_rob_id == id;
        lsb_hit = lsb_ready && lsb_rob_id == id;
        ready   = alu_hit || lsb_hit || ready_vec[id];
        value   = alu_hit ? alu_value : lsb_hit ? lsb_value : value_vec[id];
    end
endmodule

// File: rtl/rob.sv
// rob: in-order reorder buffer with bus wakeup, single commit per cycle and mispredict flush
module rob
    import rob_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    output logic                 rob_full,
    output logic [ROB_WIDTH-1:0] alloc_id,
    input  logic                 dec_ready,
    input  logic [1:0]           dec_kind,
    input  logic [4:0]           dec_rd,
    input  logic [31:0]          dec_pred_pc,
    input  logic [ROB_WIDTH-1:0] query_j_id,
    input  logic [ROB_WIDTH-1:0] query_k_id,
    output logic                 query_j_ready,
    output logic                 query_k_ready,
    output logic [31:0]          query_j_value,
    output logic [31:0]          query_k_value,
    input  logic                 alu_ready,
    input  logic [ROB_WIDTH-1:0] alu_rob_id,
    input  logic [31:0]          alu_value,
    input  logic                 lsb_ready,
    input  logic [ROB_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]          lsb_value,
    output logic                 commit_valid,
    output logic [4:0]           commit_rd,
    output logic [31:0]          commit_value,
    output logic [ROB_WIDTH-1:0] commit_rob_id,
    output logic                 commit_store,
    output logic                 clear,
    output logic [31:0]          redirect_pc
);
    logic [ROB_SIZE-1:0]        busy, ready;
    logic [ROB_SIZE-1:0][31:0]  value;
    kind_t                      kind [ROB_SIZE];
    logic [4:0]                 rd [ROB_SIZE];
    logic [31:0]                pred_pc [ROB_SIZE];
    logic [ROB_WIDTH-1:0]       head, tail;
    logic [ROB_WIDTH:0]         count;
    logic                       do_alloc, do_commit, mispredict;

    always_comb begin
        rob_full   = count == (ROB_WIDTH+1)'(ROB_SIZE);
        alloc_id   = tail;
        do_alloc   = dec_ready && !rob_full && !clear;
        do_commit  = count != '0 && busy[head] && ready[head];
        mispredict = do_commit && kind[head] == KIND_BR && value[head] != pred_pc[head];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            busy          <= '0;
            ready         <= '0;
            value         <= '0;
            commit_valid  <= 1'b0;
            commit_store  <= 1'b0;
            clear         <= 1'b0;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_rob_id <= '0;
            redirect_pc   <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                kind[i]    <= KIND_REG;
                rd[i]      <= '0;
                pred_pc[i] <= '0;
            end
        end else if (rdy_in) begin
            commit_valid <= do_commit && !mispredict;
            commit_store <= do_commit && kind[head] == KIND_ST;
            clear        <= mispredict;
            if (do_commit && !mispredict) begin
                commit_rd     <= kind[head] == KIND_REG ? rd[head] : 5'd0;
                commit_value  <= value[head];
                commit_rob_id <= head;
            end
            if (mispredict) begin
                redirect_pc <= value[head];
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                busy        <= '0;
            end else begin
                // the ROB is already empty while clear is high, so late broadcasts are dropped
                for (int i = 0; i < ROB_SIZE; i++) begin
                    if (!clear && busy[i] && alu_ready && alu_rob_id == ROB_WIDTH'(i)) begin
                        ready[i] <= 1'b1;
                        value[i] <= alu_value;
                    end
                    if (!clear && busy[i] && lsb_ready && lsb_rob_id == ROB_WIDTH'(i)) begin
                        ready[i] <= 1'b1;
                        value[i] <= lsb_value;
                    end
                end
                if (do_alloc) begin
                    busy[tail]    <= 1'b1;
                    ready[tail]   <= 1'b0;
                    kind[tail]    <= kind_t'(dec_kind);
                    rd[tail]      <= dec_rd;
                    pred_pc[tail] <= dec_pred_pc;
                    tail          <= tail + 1'b1;
                end
                if (do_commit) begin
                    busy[head] <= 1'b0;
                    head       <= head + 1'b1;
                end
                count <= count + (ROB_WIDTH+1)'(do_alloc) - (ROB_WIDTH+1)'(do_commit);
            end
        end
    end

    rob_query u_query_j (
        .id(query_j_id), .ready_vec(ready), .value_vec(value),
        .alu_ready(alu_ready), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .ready(query_j_ready), .value(query_j_value)
    );

    rob_query u_query_k (
        .id(query_k_id), .ready_vec(ready), .value_vec(value),
        .alu_ready(alu_ready), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .ready(query_k_ready), .value(query_k_value)
    );
endmodule

// File: tb/tb_rob.sv
// tb_rob: directed table, corner sequences and randomized model comparison for rob
module tb_rob;
    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
    logic        rob_full;
    logic [2:0]  alloc_id;
    logic        dec_ready = 1'b0;
    logic [1:0]  dec_kind = '0;
    logic [4:0]  dec_rd = '0;
    logic [31:0] dec_pred_pc = '0;
    logic [2:0]  query_j_id = '0, query_k_id = '0;
    logic        query_j_ready, query_k_ready;
    logic [31:0] query_j_value, query_k_value;
    logic        alu_ready = 1'b0, lsb_ready = 1'b0;
    logic [2:0]  alu_rob_id = '0, lsb_rob_id = '0;
    logic [31:0] alu_value = '0, lsb_value = '0;
    logic        commit_valid, commit_store, clear;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value, redirect_pc;
    logic [2:0]  commit_rob_id;

    int passed = 0, total = 0;

    rob dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_full(rob_full), .alloc_id(alloc_id),
        .dec_ready(dec_ready), .dec_kind(dec_kind), .dec_rd(dec_rd), .dec_pred_pc(dec_pred_pc),
        .query_j_id(query_j_id), .query_k_id(query_k_id),
        .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
        .query_j_value(query_j_value), .query_k_value(query_k_value),
        .alu_ready(alu_ready), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_rob_id(commit_rob_id), .commit_store(commit_store),
        .clear(clear), .redirect_pc(redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        dec_ready = 1'b0;
        alu_ready = 1'b0;
        lsb_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic issue(input logic [1:0] k, input logic [4:0] r, input logic [31:0] p);
        dec_ready = 1'b1;
        dec_kind = k;
        dec_rd = r;
        dec_pred_pc = p;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] dec, kind, rd, pred, au, aid, aval, lu, lid, lval;
        logic [31:0] e_alloc, e_full, e_cv, e_cs, e_clr, e_rd, e_val, e_id, e_redir;
    } vec_t;
    vec_t tv [18];

    // ---------------- reference model: program-order queue of live entries ----------------
    typedef struct {
        int          id;
        int          kind;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] pred;
        bit          rdy;
    } ment_t;
    ment_t q[$];
    int          m_tail;
    bit          e_cv, e_cs, e_clear;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_redir;
    logic [2:0]  e_id;

    function automatic void model_reset();
        q.delete();
        m_tail = 0;
        e_cv = 0; e_cs = 0; e_clear = 0;
        e_rd = '0; e_val = '0; e_redir = '0; e_id = '0;
    endfunction

    function automatic void model_step();
        bit full = q.size() == 8;
        bit old_clr = e_clear;
        bit com = q.size() > 0 && q[0].rdy;
        bit mis = com && q[0].kind == 1 && q[0].val != q[0].pred;
        e_cv = com && !mis;
        e_cs = com && q[0].kind == 2;
        e_clear = mis;
        if (com && !mis) begin
            e_rd = q[0].kind == 0 ? q[0].rd : 5'd0;
            e_val = q[0].val;
            e_id = 3'(q[0].id);
        end
        if (mis) begin
            e_redir = q[0].val;
            q.delete();
            m_tail = 0;
            return;
        end
        if (!old_clr) foreach (q[i]) begin
            if (alu_ready && alu_rob_id == 3'(q[i].id)) begin q[i].rdy = 1; q[i].val = alu_value; end
            if (lsb_ready && lsb_rob_id == 3'(q[i].id)) begin q[i].rdy = 1; q[i].val = lsb_value; end
        end
        if (com) void'(q.pop_front());
        if (dec_ready && !full && !old_clr) begin
            q.push_back('{m_tail, int'(dec_kind), dec_rd, 32'd0, dec_pred_pc, 1'b0});
            m_tail = (m_tail + 1) % 8;
        end
    endfunction

    task automatic chk_query(input string n, input logic [2:0] id, input logic r, input logic [31:0] v);
        if (alu_ready && alu_rob_id == id) begin
            chk({n, "_ready"}, 32'(r), 32'd1);
            chk({n, "_value"}, v, alu_value);
        end else if (lsb_ready && lsb_rob_id == id) begin
            chk({n, "_ready"}, 32'(r), 32'd1);
            chk({n, "_value"}, v, lsb_value);
        end else foreach (q[i]) if (3'(q[i].id) == id) begin
            chk({n, "_ready"}, 32'(r), 32'(q[i].rdy));
            if (q[i].rdy) chk({n, "_value"}, v, q[i].val);
        end
    endtask

    task automatic pick_bus(output logic [2:0] id, output logic [31:0] v);
        int k;
        if (q.size() > 0 && $urandom_range(4) != 0) begin
            k = $urandom_range(q.size() - 1);
            id = 3'(q[k].id);
            v = (q[k].kind == 1 && $urandom_range(1) == 1) ? q[k].pred : $urandom;
        end else begin
            id = 3'($urandom_range(7));
            v = $urandom;
        end
    endtask

    initial begin
        tv[0]  = '{1,0,5,0,     0,0,0,      0,0,0,       0,0,0,0,0,0,0,0,0};
        tv[1]  = '{1,0,6,0,     0,0,0,      0,0,0,       1,0,0,0,0,0,0,0,0};
        tv[2]  = '{0,0,0,0,     1,1,'h22,   0,0,0,       2,0,0,0,0,0,0,0,0};
        tv[3]  = '{0,0,0,0,     1,0,'h11,   0,0,0,       2,0,0,0,0,0,0,0,0};
        tv[4]  = '{0,0,0,0,     0,0,0,      0,0,0,       2,0,1,0,0,5,'h11,0,0};
        tv[5]  = '{0,0,0,0,     0,0,0,      0,0,0,       2,0,1,0,0,6,'h22,1,0};
        tv[6]  = '{0,0,0,0,     0,0,0,      0,0,0,       2,0,0,0,0,0,0,0,0};
        tv[7]  = '{1,1,0,'h104, 0,0,0,      0,0,0,       2,0,0,0,0,0,0,0,0};
        tv[8]  = '{1,0,9,0,     0,0,0,      0,0,0,       3,0,0,0,0,0,0,0,0};
        tv[9]  = '{0,0,0,0,     1,2,'h200,  1,3,'h33,    4,0,0,0,0,0,0,0,0};
        tv[10] = '{0,0,0,0,     0,0,0,      0,0,0,       4,0,0,0,1,0,0,0,'h200};
        tv[11] = '{1,0,1,0,     0,0,0,      0,0,0,       0,0,0,0,0,0,0,0,0};
        tv[12] = '{0,0,0,0,     0,0,0,      0,0,0,       0,0,0,0,0,0,0,0,0};
        tv[13] = '{1,1,7,'h40,  0,0,0,      0,0,0,       0,0,0,0,0,0,0,0,0};
        tv[14] = '{1,2,3,0,     1,0,'h40,   0,0,0,       1,0,0,0,0,0,0,0,0};
        tv[15] = '{0,0,0,0,     0,0,0,      1,1,'h1000,  2,0,1,0,0,0,'h40,0,0};
        tv[16] = '{0,0,0,0,     0,0,0,      0,0,0,       2,0,1,1,0,0,'h1000,1,0};
        tv[17] = '{0,0,0,0,     0,0,0,      0,0,0,       2,0,0,0,0,0,0,0,0};

        tick();
        chk("reset_commit_valid", 32'(commit_valid), 0);
        chk("reset_clear", 32'(clear), 0);
        rst_in = 1'b0;
        chk("reset_alloc_id", 32'(alloc_id), 0);
        chk("reset_full", 32'(rob_full), 0);

        for (int i = 0; i < $size(tv); i++) begin
            dec_ready = tv[i].dec[0]; dec_kind = tv[i].kind[1:0];
            dec_rd = tv[i].rd[4:0]; dec_pred_pc = tv[i].pred;
            alu_ready = tv[i].au[0]; alu_rob_id = tv[i].aid[2:0]; alu_value = tv[i].aval;
            lsb_ready = tv[i].lu[0]; lsb_rob_id = tv[i].lid[2:0]; lsb_value = tv[i].lval;
            #1;
            chk($sformatf("tv%0d_alloc_id", i), 32'(alloc_id), tv[i].e_alloc);
            chk($sformatf("tv%0d_full", i), 32'(rob_full), tv[i].e_full);
            tick();
            chk($sformatf("tv%0d_commit_valid", i), 32'(commit_valid), tv[i].e_cv);
            chk($sformatf("tv%0d_commit_store", i), 32'(commit_store), tv[i].e_cs);
            chk($sformatf("tv%0d_clear", i), 32'(clear), tv[i].e_clr);
            if (tv[i].e_cv[0]) begin
                chk($sformatf("tv%0d_commit_rd", i), 32'(commit_rd), tv[i].e_rd);
                chk($sformatf("tv%0d_commit_value", i), commit_value, tv[i].e_val);
                chk($sformatf("tv%0d_commit_id", i), 32'(commit_rob_id), tv[i].e_id);
            end
            if (tv[i].e_clr[0]) chk($sformatf("tv%0d_redirect", i), redirect_pc, tv[i].e_redir);
        end

        // full and wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue(2'd0, 5'(i + 1), 0);
            #1;
            chk("fill_alloc_id", 32'(alloc_id), 32'(i));
            tick();
        end
        chk("full_set", 32'(rob_full), 1);
        chk("full_alloc_id", 32'(alloc_id), 0);
        issue(2'd0, 5'd31, 0);
        tick();
        chk("ninth_ignored_full", 32'(rob_full), 1);
        chk("ninth_ignored_alloc", 32'(alloc_id), 0);
        idle();
        alu_ready = 1'b1; alu_rob_id = 3'd0; alu_value = 32'h55;
        tick();
        idle();
        tick();
        chk("wrap_commit_valid", 32'(commit_valid), 1);
        chk("wrap_commit_id", 32'(commit_rob_id), 0);
        chk("wrap_commit_rd", 32'(commit_rd), 1);
        chk("wrap_commit_value", commit_value, 32'h55);
        chk("wrap_not_full", 32'(rob_full), 0);
        issue(2'd0, 5'd9, 0);
        #1;
        chk("wrap_alloc_id", 32'(alloc_id), 0);
        tick();
        idle();
        chk("refull", 32'(rob_full), 1);
        chk("refull_alloc_id", 32'(alloc_id), 1);

        // stall holds state and pulses
        do_reset();
        issue(2'd0, 5'd4, 0);
        tick();
        idle();
        alu_ready = 1'b1; alu_rob_id = 3'd0; alu_value = 32'h77;
        tick();
        idle();
        rdy_in = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_commit", 32'(commit_valid), 0);
            chk("stall_alloc_id", 32'(alloc_id), 1);
        end
        dec_ready = 1'b0;
        rdy_in = 1'b1;
        tick();
        chk("unstall_commit", 32'(commit_valid), 1);
        chk("unstall_value", commit_value, 32'h77);
        chk("unstall_alloc_id", 32'(alloc_id), 1);
        rdy_in = 1'b0;
        tick();
        chk("stall_holds_pulse", 32'(commit_valid), 1);
        rdy_in = 1'b1;
        tick();
        chk("pulse_drops", 32'(commit_valid), 0);

        // bypass query
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(2'd0, 5'(i), 0);
            tick();
        end
        idle();
        alu_ready = 1'b1; alu_rob_id = 3'd3; alu_value = 32'hABCD;
        query_j_id = 3'd3; query_k_id = 3'd2;
        #1;
        chk("bypass_j_ready", 32'(query_j_ready), 1);
        chk("bypass_j_value", query_j_value, 32'hABCD);
        chk("bypass_k_not_ready", 32'(query_k_ready), 0);
        tick();
        idle();
        lsb_ready = 1'b1; lsb_rob_id = 3'd2; lsb_value = 32'h5A5A;
        #1;
        chk("stored_j_ready", 32'(query_j_ready), 1);
        chk("stored_j_value", query_j_value, 32'hABCD);
        chk("bypass_k_ready", 32'(query_k_ready), 1);
        chk("bypass_k_value", query_k_value, 32'h5A5A);
        idle();

        // asynchronous reset mid-operation
        do_reset();
        issue(2'd0, 5'd1, 0);
        tick();
        alu_ready = 1'b1; alu_rob_id = 3'd0; alu_value = 32'h9;
        tick();
        alu_ready = 1'b0;
        tick();
        idle();
        chk("pre_reset_commit", 32'(commit_valid), 1);
        chk("pre_reset_alloc", 32'(alloc_id), 3);
        #2 rst_in = 1'b1;
        #1;
        chk("async_rst_full", 32'(rob_full), 0);
        chk("async_rst_alloc", 32'(alloc_id), 0);
        chk("async_rst_commit", 32'(commit_valid), 0);
        tick();
        rst_in = 1'b0;

        // randomized run against the queue model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [2:0]  aid, lid;
            logic [31:0] av, lv;
            rdy_in = $urandom_range(9) != 0;
            dec_ready = $urandom_range(1) == 1;
            dec_kind = 2'($urandom_range(2));
            dec_rd = 5'($urandom_range(31));
            dec_pred_pc = $urandom;
            pick_bus(aid, av);
            pick_bus(lid, lv);
            alu_ready = $urandom_range(1) == 1; alu_rob_id = aid; alu_value = av;
            lsb_ready = $urandom_range(1) == 1 && !(alu_ready && lid == aid);
            lsb_rob_id = lid; lsb_value = lv;
            query_j_id = 3'($urandom_range(7));
            query_k_id = 3'($urandom_range(7));
            #1;
            chk("rnd_full", 32'(rob_full), 32'(q.size() == 8));
            chk("rnd_alloc_id", 32'(alloc_id), 32'(m_tail));
            chk_query("rnd_qj", query_j_id, query_j_ready, query_j_value);
            chk_query("rnd_qk", query_k_id, query_k_ready, query_k_value);
            @(posedge clk_in);
            if (rdy_in) model_step();
            #1;
            chk("rnd_commit_valid", 32'(commit_valid), 32'(e_cv));
            chk("rnd_commit_store", 32'(commit_store), 32'(e_cs));
            chk("rnd_clear", 32'(clear), 32'(e_clear));
            if (e_cv) begin
                chk("rnd_commit_rd", 32'(commit_rd), 32'(e_rd));
                chk("rnd_commit_value", commit_value, e_val);
                chk("rnd_commit_id", 32'(commit_rob_id), 32'(e_id));
            end
            if (e_clear) chk("rnd_redirect", redirect_pc, e_redir);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
